benes_cfg_loader: RTL and testbench
===================================

Name: benes_cfg_loader

Overview:
- Configuration front-end for the 8x8 Benes datapath. It sits directly upstream of every stage instance and drives each stage's 4-bit switch_set.
- Accepts per-stage switch words over a valid/ready write port into a shadow bank. Once a full configuration is staged, it commits the whole bank to the active bank atomically on a frame boundary.
- The routing pattern therefore never changes mid-frame, and never shows a partially written configuration.

Parameters:
- NUM_STAGES, 5, number of Benes stages (2*log2(8)-1).
- SW_PER_STAGE, 4, 2x2 switches per stage; also the width of each stage's switch_set.
- IDX_W, 3, width of the stage index; must satisfy 2**IDX_W >= NUM_STAGES.

Ports:
- clk  input  1  single clock for the whole block.
- rst  input  1  synchronous, active-high reset.
- cfg_valid  input  1  write request.
- cfg_ready  output  1  block can accept a write this cycle.
- cfg_stage  input  IDX_W  target stage index.
- cfg_data  input  SW_PER_STAGE  switch word for that stage; bit i controls switch i (1 = cross, 0 = bar).
- cfg_last  input  1  marks the final write of a configuration.
- frame_sync  input  1  one-cycle pulse at each data frame boundary.
- switch_set_flat  output  NUM_STAGES*SW_PER_STAGE  active bank; bits [s*SW_PER_STAGE +: SW_PER_STAGE] feed stage s.
- cfg_pending  output  1  a complete configuration is staged and awaiting frame_sync.
- commit_done  output  1  one-cycle pulse: active bank was updated this cycle.
- cfg_error  output  1  one-cycle pulse: a write or configuration was rejected.

Behaviour:
- All outputs are registered.

Reset (rst=1 at a clk edge):
- Active and shadow banks cleared to 0, so every switch is in bar/pass-through.
- Written-mask cleared; FSM goes to IDLE.
- Outputs: cfg_ready=0 while rst is high, 1 the cycle after rst deasserts; cfg_pending=0, commit_done=0, cfg_error=0.
- A reset in the middle of a load discards all staged data. The active bank also returns to 0.

Accepted write: cfg_valid & cfg_ready.

FSM states:
- IDLE: cfg_ready=1. An accepted write with cfg_stage < NUM_STAGES stores cfg_data into shadow[cfg_stage] and sets mask[cfg_stage]. Next state is LOAD, or the cfg_last rule applies.
- LOAD: cfg_ready=1. Same write rule. Rewriting a stage overwrites its shadow word (last write wins).
- PENDING: cfg_ready=0 and cfg_pending=1; writes are stalled.
  - On frame_sync: active bank <= shadow bank, mask cleared, next state IDLE.
  - commit_done pulses in the same cycle switch_set_flat shows the new value, i.e. the cycle after frame_sync is sampled (latency 1).
  - The shadow bank keeps its contents, so an identical configuration can be re-committed after rewriting all stages.

cfg_last rule:
- The accepted write carrying cfg_last=1 is itself stored first.
- If (mask | this write's bit) is all ones, go to PENDING; cfg_pending=1 from the next cycle.
- Otherwise pulse cfg_error, clear the mask and go to IDLE. The shadow words are left as is but are not committable.

Rejected writes and error pulses:
- A write with cfg_stage >= NUM_STAGES is accepted (handshake completes) but not stored, and cfg_error pulses.
- If that write also carries cfg_last, the configuration is rejected as incomplete: one cfg_error pulse, mask cleared, go to IDLE.

frame_sync outside PENDING:
- No effect; the active bank is held.

Simultaneous events:
- A completing cfg_last write and frame_sync in the same cycle: no commit that cycle, because the state was not yet PENDING. The commit happens on the next frame_sync.
- cfg_valid is held in PENDING: no acceptance; the write waits until IDLE.

Stability:
- switch_set_flat changes only on a commit or on reset. There is never a partial update.

Test Plan:
1. Reset, then idle: switch_set_flat=0, cfg_ready=1, cfg_pending=0 -> apply frame_sync; output stays 0 and commit_done stays 0.
2. Write stages 0..4 with 0x1,0x2,0x4,0x8,0xF, cfg_last on stage 4 -> cfg_pending=1 and cfg_ready=0. Then frame_sync -> the next cycle switch_set_flat=20'hF8421, commit_done=1 for one cycle, and the FSM is back in IDLE.
3. Write stages 0,1,2 then stage 3 with cfg_last -> cfg_error pulses once, no pending. A following frame_sync leaves the active bank unchanged.
4. Write stage 2 twice (0x3, then 0xC) within a full load; after the commit, bits [11:8]=0xC. A write to stage 6 -> cfg_error pulses and the active bank is unaffected after the next commit.
5. The completing cfg_last write coincides with frame_sync -> no commit that cycle. The next frame_sync commits, and commit_done asserts exactly once.
6. Commit a pattern, start a new load (stages 0,1), assert rst for one cycle -> active bank=0, cfg_pending=0. A subsequent full load and commit works normally.

Source files
------------

// File: rtl/benes_cfg_loader.sv
// ============================================================================
// Module      : benes_cfg_loader
// Description : Shadow/active switch-setting banks for the 8x8 Benes datapath;
//               a complete staged configuration is committed on frame_sync.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module benes_cfg_loader #(
    parameter int NUM_STAGES   = 5,
    parameter int SW_PER_STAGE = 4,
    parameter int IDX_W        = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cfg_valid,
    output logic                               cfg_ready,
    input  logic [IDX_W-1:0]                   cfg_stage,
    input  logic [SW_PER_STAGE-1:0]            cfg_data,
    input  logic                               cfg_last,
    input  logic                               frame_sync,
    output logic [NUM_STAGES*SW_PER_STAGE-1:0] switch_set_flat,
    output logic                               cfg_pending,
    output logic                               commit_done,
    output logic                               cfg_error
);

    localparam int             c_BANK_W  = NUM_STAGES * SW_PER_STAGE;
    localparam logic [IDX_W:0] c_NUM_STG = NUM_STAGES[IDX_W:0];

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_LOAD    = 2'd1;
    localparam logic [1:0] c_PENDING = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [NUM_STAGES-1:0] r_mask;
    logic [NUM_STAGES-1:0] w_mask_nxt;
    logic [NUM_STAGES-1:0] w_wr_bit;
    logic [c_BANK_W-1:0]   r_shadow;
    logic [c_BANK_W-1:0]   r_active;
    logic                  r_ready;
    logic                  r_pending;
    logic                  r_commit;
    logic                  r_error;
    logic                  w_accept;
    logic                  w_stage_ok;
    logic                  w_commit;
    logic                  w_error;

    always_comb begin
        w_accept   = cfg_valid & r_ready;
        w_stage_ok = ({1'b0, cfg_stage} < c_NUM_STG);
        w_wr_bit   = '0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            w_wr_bit[s] = w_accept && w_stage_ok && (cfg_stage == s[IDX_W-1:0]);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_commit    = 1'b0;
        w_error     = 1'b0;
        case (r_state)
            c_IDLE, c_LOAD: begin
                if (w_accept) begin
                    w_mask_nxt = r_mask | w_wr_bit;
                    if (w_stage_ok) begin
                        w_state_nxt = c_LOAD;
                    end else begin
                        w_error = 1'b1;
                    end
                    // An out-of-range last write already flags once; no second pulse.
                    if (cfg_last) begin
                        if (w_stage_ok && (&w_mask_nxt)) begin
                            w_state_nxt = c_PENDING;
                        end else begin
                            w_error     = 1'b1;
                            w_mask_nxt  = '0;
                            w_state_nxt = c_IDLE;
                        end
                    end
                end
            end
            c_PENDING: begin
                if (frame_sync) begin
                    w_commit    = 1'b1;
                    w_mask_nxt  = '0;
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_mask    <= '0;
            r_shadow  <= '0;
            r_active  <= '0;
            r_ready   <= 1'b0;
            r_pending <= 1'b0;
            r_commit  <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mask    <= w_mask_nxt;
            r_ready   <= (w_state_nxt != c_PENDING);
            r_pending <= (w_state_nxt == c_PENDING);
            r_commit  <= w_commit;
            r_error   <= w_error;
            if (w_commit) begin
                r_active <= r_shadow;
            end
            for (int s = 0; s < NUM_STAGES; s++) begin
                if (w_wr_bit[s]) begin
                    r_shadow[s*SW_PER_STAGE +: SW_PER_STAGE] <= cfg_data;
                end
            end
        end
    end

    assign cfg_ready       = r_ready;
    assign cfg_pending     = r_pending;
    assign commit_done     = r_commit;
    assign cfg_error       = r_error;
    assign switch_set_flat = r_active;

endmodule

`default_nettype wire

// File: tb/tb_benes_cfg_loader.sv
// ============================================================================
// Module      : tb_benes_cfg_loader
// Description : Scoreboard bench for benes_cfg_loader with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_benes_cfg_loader;

    localparam int NS = 5;
    localparam int SW = 4;
    localparam int IW = 3;
    localparam int BW = NS * SW;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          cfg_valid  = 1'b0;
    logic [IW-1:0] cfg_stage  = '0;
    logic [SW-1:0] cfg_data   = '0;
    logic          cfg_last   = 1'b0;
    logic          frame_sync = 1'b0;
    logic          cfg_ready;
    logic          cfg_pending;
    logic          commit_done;
    logic          cfg_error;
    logic [BW-1:0] switch_set_flat;

    always #5 clk = ~clk;

    benes_cfg_loader #(
        .NUM_STAGES  (NS),
        .SW_PER_STAGE(SW),
        .IDX_W       (IW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_stage      (cfg_stage),
        .cfg_data       (cfg_data),
        .cfg_last       (cfg_last),
        .frame_sync     (frame_sync),
        .switch_set_flat(switch_set_flat),
        .cfg_pending    (cfg_pending),
        .commit_done    (commit_done),
        .cfg_error      (cfg_error)
    );

    typedef struct {
        bit            is_commit;
        logic [BW-1:0] val;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    // Reference model: plain arrays of stage words plus a "which stages written" set.
    int  m_shadow [NS];
    int  m_active [NS];
    bit  m_written[NS];
    bit  m_pending = 1'b0;
    bit  m_ready   = 1'b0;

    function automatic logic [BW-1:0] model_flat();
        logic [BW-1:0] r;
        r = '0;
        for (int s = 0; s < NS; s++) r[s*SW +: SW] = m_active[s][SW-1:0];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_step();
        bit   acc;
        bit   ok;
        bit   all_w;
        ev_t  e;
        acc = cfg_valid && m_ready;
        if (rst) begin
            for (int s = 0; s < NS; s++) begin
                m_shadow[s] = 0; m_active[s] = 0; m_written[s] = 1'b0;
            end
            m_pending = 1'b0;
            m_ready   = 1'b0;
        end else begin
            if (m_pending) begin
                if (frame_sync) begin
                    m_active = m_shadow;
                    e.is_commit = 1'b1; e.val = model_flat();
                    exp_q.push_back(e);
                    m_pending = 1'b0;
                    for (int s = 0; s < NS; s++) m_written[s] = 1'b0;
                end
            end else if (acc) begin
                ok = (int'(cfg_stage) < NS);
                if (ok) begin
                    m_shadow[cfg_stage]  = int'(cfg_data);
                    m_written[cfg_stage] = 1'b1;
                end else begin
                    e.is_commit = 1'b0; e.val = '0;
                    exp_q.push_back(e);
                end
                if (cfg_last) begin
                    all_w = 1'b1;
                    for (int s = 0; s < NS; s++) all_w &= m_written[s];
                    if (ok && all_w) begin
                        m_pending = 1'b1;
                    end else begin
                        if (ok) begin
                            e.is_commit = 1'b0; e.val = '0;
                            exp_q.push_back(e);
                        end
                        for (int s = 0; s < NS; s++) m_written[s] = 1'b0;
                    end
                end
            end
            m_ready = !m_pending;
        end
    endtask

    task automatic drive(input bit v, input logic [IW-1:0] st, input logic [SW-1:0] d,
                         input bit l, input bit fs, input bit r);
        @(negedge clk);
        cfg_valid = v; cfg_stage = st; cfg_data = d; cfg_last = l;
        frame_sync = fs; rst = r;
        @(posedge clk);
        model_step();
    endtask

    task automatic idle(input bit fs);
        drive(1'b0, '0, '0, 1'b0, fs, 1'b0);
    endtask

    task automatic write(input logic [IW-1:0] st, input logic [SW-1:0] d, input bit l, input bit fs);
        int guard;
        guard = 0;
        while (!m_ready && guard < 50) begin
            idle(1'b0);
            guard++;
        end
        if (!m_ready) begin
            check("write_wait_timeout", 32'(m_ready), 32'd1);
        end else begin
            drive(1'b1, st, d, l, fs, 1'b0);
        end
    endtask

    task automatic full_load(input logic [SW-1:0] d0, input logic [SW-1:0] d1, input logic [SW-1:0] d2,
                             input logic [SW-1:0] d3, input logic [SW-1:0] d4);
        write(3'd0, d0, 1'b0, 1'b0);
        write(3'd1, d1, 1'b0, 1'b0);
        write(3'd2, d2, 1'b0, 1'b0);
        write(3'd3, d3, 1'b0, 1'b0);
        write(3'd4, d4, 1'b1, 1'b0);
    endtask

    // Monitor: per-cycle state comparison plus scoreboard pops on output pulses.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("switch_set_flat", 32'(switch_set_flat), 32'(model_flat()));
            check("cfg_ready", 32'(cfg_ready), 32'(m_ready));
            check("cfg_pending", 32'(cfg_pending), 32'(m_pending));
            check("commit_done", 32'(commit_done), 32'(exp_q.size() > 0 && exp_q[0].is_commit));
            if (commit_done && exp_q.size() > 0 && exp_q[0].is_commit) begin
                check("commit_value", 32'(switch_set_flat), 32'(exp_q[0].val));
                void'(exp_q.pop_front());
            end
            check("cfg_error", 32'(cfg_error), 32'(exp_q.size() > 0 && !exp_q[0].is_commit));
            if (cfg_error && exp_q.size() > 0 && !exp_q[0].is_commit) void'(exp_q.pop_front());
            if (exp_q.size() != 0) begin
                check("event_missing", 32'(exp_q.size()), 32'd0);
                exp_q.delete();
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset and idle frame_sync
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // Full load and commit
        full_load(4'h1, 4'h2, 4'h4, 4'h8, 4'hF);
        idle(1'b0);
        idle(1'b1);
        #1 check("tp2_flat", 32'(switch_set_flat), 32'h000F8421);
        check("tp2_commit", 32'(commit_done), 32'd1);
        idle(1'b0);

        // Incomplete configuration
        write(3'd0, 4'h3, 1'b0, 1'b0);
        write(3'd1, 4'h3, 1'b0, 1'b0);
        write(3'd2, 4'h3, 1'b0, 1'b0);
        write(3'd3, 4'h3, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b0);
        #1 check("tp3_flat", 32'(switch_set_flat), 32'h000F8421);

        // Overwrite then out-of-range stage
        write(3'd0, 4'h5, 1'b0, 1'b0);
        write(3'd1, 4'h6, 1'b0, 1'b0);
        write(3'd2, 4'h3, 1'b0, 1'b0);
        write(3'd2, 4'hC, 1'b0, 1'b0);
        write(3'd3, 4'h7, 1'b0, 1'b0);
        write(3'd4, 4'h9, 1'b1, 1'b0);
        idle(1'b1);
        #1 check("tp4_stage2", 32'(switch_set_flat[11:8]), 32'hC);
        write(3'd6, 4'hA, 1'b0, 1'b0);
        full_load(4'h1, 4'h1, 4'h1, 4'h1, 4'h1);
        idle(1'b1);
        #1 check("tp4_flat", 32'(switch_set_flat), 32'h00011111);

        // Completing write coincides with frame_sync
        write(3'd0, 4'hE, 1'b0, 1'b0);
        write(3'd1, 4'hD, 1'b0, 1'b0);
        write(3'd2, 4'hB, 1'b0, 1'b0);
        write(3'd3, 4'h7, 1'b0, 1'b0);
        write(3'd4, 4'h6, 1'b1, 1'b1);
        idle(1'b0);
        #1 check("tp5_no_early_commit", 32'(switch_set_flat), 32'h00011111);
        idle(1'b1);
        idle(1'b0);

        // Reset in the middle of a load
        write(3'd0, 4'h2, 1'b0, 1'b0);
        write(3'd1, 4'h4, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        #1 check("tp6_flat_reset", 32'(switch_set_flat), 32'd0);
        idle(1'b0);
        full_load(4'h9, 4'h8, 4'h7, 4'h6, 4'h5);
        idle(1'b1);
        idle(1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)),
                  4'($urandom),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 299) == 0));
        end
        idle(1'b0);
        idle(1'b0);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
